// File: rtl/pc_stack_unit.sv
// Program counter with increment, absolute jump, relative branch and a
// bounded LIFO return stack for call/return; illegal stack use sets a sticky flag.
module pc_stack_unit #(
    parameter int               WIDTH        = 4,
    parameter int               DEPTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             MainClock,
    input  logic             ClearCounter,
    input  logic             EnableCount,
    input  logic             LoadPC,
    input  logic             BranchRel,
    input  logic             Call,
    input  logic             Ret,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic [WIDTH-1:0] Offset,
    output logic [WIDTH-1:0] PC,
    output logic             Wrap,
    output logic             StackEmpty,
    output logic             StackFull,
    output logic             StackErr
);

    localparam int            DW        = $clog2(DEPTH + 1);
    localparam int            SLOTS     = 1 << DW;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] ONE       = DW'(1);

    // Sized to the full depth-counter range so the counter indexes it directly;
    // slots at or above DEPTH are never written.
    logic [WIDTH-1:0] stack_mem [SLOTS];

    logic [DW-1:0]    depth;
    logic [DW-1:0]    depth_nxt;
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] push_data;
    logic             push_en;
    logic             wrap_nxt;
    logic             err_nxt;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   br_sum;

    assign inc_sum = {1'b0, PC} + {{WIDTH{1'b0}}, 1'b1};
    // Sign-extending Offset one bit makes bit WIDTH a carry for positive
    // offsets and a borrow for negative ones.
    assign br_sum  = {1'b0, PC} + {Offset[WIDTH-1], Offset};

    assign StackEmpty = (depth == '0);
    assign StackFull  = (depth == DEPTH_MAX);

    always_comb begin
        pc_nxt    = PC;
        depth_nxt = depth;
        wrap_nxt  = 1'b0;
        err_nxt   = StackErr;
        push_en   = 1'b0;
        push_data = inc_sum[WIDTH-1:0];
        if (EnableCount) begin
            if (Ret) begin
                if (!StackEmpty) begin
                    pc_nxt    = stack_mem[depth - ONE];
                    depth_nxt = depth - ONE;
                end else begin
                    err_nxt = 1'b1;
                end
            end else if (Call) begin
                if (!StackFull) begin
                    push_en   = 1'b1;
                    pc_nxt    = LoadValue;
                    depth_nxt = depth + ONE;
                end else begin
                    err_nxt = 1'b1;
                end
            end else if (LoadPC) begin
                pc_nxt = LoadValue;
            end else if (BranchRel) begin
                pc_nxt   = br_sum[WIDTH-1:0];
                wrap_nxt = br_sum[WIDTH];
            end else begin
                pc_nxt   = inc_sum[WIDTH-1:0];
                wrap_nxt = inc_sum[WIDTH];
            end
        end
    end

    always_ff @(posedge MainClock or negedge ClearCounter) begin
        if (!ClearCounter) begin
            PC       <= RESET_VECTOR;
            depth    <= '0;
            Wrap     <= 1'b0;
            StackErr <= 1'b0;
        end else begin
            PC       <= pc_nxt;
            depth    <= depth_nxt;
            Wrap     <= wrap_nxt;
            StackErr <= err_nxt;
        end
    end

    // Stack storage needs no reset: depth=0 makes every entry unreachable.
    always_ff @(posedge MainClock) begin
        if (push_en && ClearCounter) begin
            stack_mem[depth] <= push_data;
        end
    end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, program-counter width in bits (2..16).
REQ-002 The module SHALL have parameter DEPTH, default 4, return-stack entries (1..8).
REQ-003 The module SHALL have parameter RESET_VECTOR, default 0, PC value after reset (WIDTH bits).
REQ-004 MainClock  input  1  sole clock; all state updates on its rising edge.
REQ-005 ClearCounter  input  1  asynchronous, active-low reset.
REQ-006 EnableCount  input  1  cycle qualifier; no state change except reset when 0.
REQ-007 LoadPC  input  1  absolute jump request.
REQ-008 BranchRel  input  1  relative branch request.
REQ-009 Call  input  1  subroutine call request.
REQ-010 Ret  input  1  subroutine return request.
REQ-011 LoadValue  input  WIDTH  jump/call target.
REQ-012 Offset  input  WIDTH  two's-complement relative offset.
REQ-013 PC  output  WIDTH  current program counter, registered.
REQ-014 Wrap  output  1  one-cycle pulse: last PC update crossed modulo 2^WIDTH.
REQ-015 StackEmpty  output  1  return stack holds 0 entries.
REQ-016 StackFull  output  1  return stack holds DEPTH entries.
REQ-017 StackErr  output  1  sticky: illegal call/return occurred.

Function
REQ-018 Requests SHALL be sampled only on rising MainClock edges with EnableCount=1; EnableCount=0 holds PC, stack and StackErr, and drives Wrap=0 next cycle.
REQ-019 With EnableCount=1, priority SHALL be Ret > Call > LoadPC > BranchRel > increment; lower-priority requests in the same cycle are ignored.
REQ-020 Increment: PC <= PC+1 mod 2^WIDTH; Wrap=1 next cycle iff PC was 2^WIDTH-1.
REQ-021 LoadPC: PC <= LoadValue; Wrap=0.
REQ-022 BranchRel: PC <= PC+sign-extended Offset mod 2^WIDTH; Wrap=1 iff the unsigned result left range [0, 2^WIDTH-1] (carry out for positive Offset, borrow for negative).
REQ-023 Call with stack not full: push (PC+1 mod 2^WIDTH), PC <= LoadValue, depth +1, same edge.
REQ-024 Call with stack full: no push, PC holds, StackErr <= 1.
REQ-025 Ret with stack not empty: PC <= top entry, pop, depth -1, same edge.
REQ-026 Ret with stack empty: PC holds, StackErr <= 1.
REQ-027 Stack SHALL be LIFO; depth counter range 0..DEPTH; StackEmpty=(depth==0), StackFull=(depth==DEPTH), both combinational from registered depth.
REQ-028 Wrap SHALL be registered, high for exactly one cycle per wrapping update, 0 for Ret/Call/LoadPC cycles.
REQ-029 StackErr SHALL remain 1 until reset; it does not block further operations.
REQ-030 Simultaneous Call and Ret SHALL execute Ret only.

Reset
REQ-031 ClearCounter=0 SHALL immediately, independent of MainClock, set PC=RESET_VECTOR, depth=0, Wrap=0, StackErr=0, StackEmpty=1, StackFull=0 (StackFull=1 never at reset since DEPTH>=1).
REQ-032 Reset asserted mid-operation SHALL discard the in-flight request; stack contents need not be cleared but SHALL be unreachable (depth=0).
REQ-033 After ClearCounter deasserts, first update SHALL occur on the first rising edge with EnableCount=1.

Verification
REQ-034 WIDTH=4: reset, EnableCount=1 for 16 edges -> PC 1,2..15,0; Wrap=1 only in cycle after PC 15->0.
REQ-035 PC=3, BranchRel, Offset=4'b1110 (-2) -> PC=1, Wrap=0; PC=14, Offset=3 -> PC=1, Wrap=1.
REQ-036 DEPTH=2: PC=5 Call LoadValue=10 -> PC=10, StackEmpty=0; Call LoadValue=12 -> PC=12, StackFull=1; Call again -> PC=12, StackErr=1; Ret -> PC=11; Ret -> PC=6, StackEmpty=1.
REQ-037 StackEmpty=1, Ret -> PC unchanged, StackErr=1 stays through later increments.
REQ-038 LoadPC=1, BranchRel=1, Ret=1 with empty stack, EnableCount=1 -> Ret wins: PC holds, StackErr=1; EnableCount=0 with LoadPC=1 -> PC holds.
REQ-039 ClearCounter pulsed low between clock edges with depth=2 -> PC=RESET_VECTOR, StackEmpty=1, StackErr=0 before next edge.
